// File: rtl/sm4_decrypt_stream.sv
// sm4_decrypt_stream: streaming SM4 (GB/T 32907) block decryptor.
//
// A 128-bit master key is accepted once and expanded into 32 round keys,
// one per cycle, into a local store. Each ciphertext block is then decrypted
// with one round per cycle, using the round keys in reverse order. The
// S-box/T datapath is shared by key expansion and decryption.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   key_valid/key_ready   key channel, key = MK with MK0 = key[127:96]
//   in_valid/in_ready     ciphertext channel, X0 = in_data[127:96]
//   out_valid/out_ready   plaintext channel, out_data = {X35,X34,X33,X32}
//   key_loaded            a complete round-key set is stored
//   state_dbg             current FSM state (debug visibility)
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A producer holds valid and data stable until the transfer; ready may be
// asserted independently of valid. A key offer in READY takes priority over
// a data offer in the same cycle (in_ready drops while key_valid is high).

module sm4_decrypt_stream #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [WIDTH-1:0] key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             key_loaded,
    output logic [2:0]       state_dbg
);

    if (WIDTH != 128) begin : g_width_check
        $error("sm4_decrypt_stream: WIDTH must be 128");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYEXP = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Registered state
    logic [2:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] win_q, win_d;      // K or X sliding window, word 0 in [127:96]
    logic         key_loaded_q, key_loaded_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [31:0]  rk_q [32];         // round-key store, indexed by round number
    logic         rk_we;

    // Shared round datapath
    logic [31:0] w0, w1, w2, w3;
    logic [7:0]  ck_b0;
    logic [31:0] ck;
    logic [31:0] rk_rd;
    logic [31:0] mix;
    logic [31:0] sb;
    logic [31:0] l_enc;
    logic [31:0] l_key;
    logic        is_keyexp;
    logic [31:0] new_word;

    assign w0 = win_q[127:96];
    assign w1 = win_q[95:64];
    assign w2 = win_q[63:32];
    assign w3 = win_q[31:0];

    // CK byte j of round i is (4i+j)*7 mod 256, so the lead byte is 28*i
    // and the others follow in steps of 7 (8-bit wrap gives the mod).
    assign ck_b0 = {3'b000, cnt_q} * 8'd28;
    assign ck    = {ck_b0, ck_b0 + 8'd7, ck_b0 + 8'd14, ck_b0 + 8'd21};

    // Decryption walks the store backwards: round n uses rk[31-n].
    assign rk_rd     = rk_q[~cnt_q];
    assign is_keyexp = (state_q == S_KEYEXP);
    assign mix       = w1 ^ w2 ^ w3 ^ (is_keyexp ? ck : rk_rd);
    assign sb        = {SBOX[mix[31:24]], SBOX[mix[23:16]], SBOX[mix[15:8]], SBOX[mix[7:0]]};
    assign l_enc     = sb ^ rotl(sb, 2) ^ rotl(sb, 10) ^ rotl(sb, 18) ^ rotl(sb, 24);
    assign l_key     = sb ^ rotl(sb, 13) ^ rotl(sb, 23);
    assign new_word  = w0 ^ (is_keyexp ? l_key : l_enc);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        key_loaded_d = key_loaded_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        rk_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    win_d   = key ^ FK;
                    cnt_d   = 5'd0;
                    state_d = S_KEYEXP;
                end
            end
            S_KEYEXP: begin
                rk_we = 1'b1;
                win_d = {w1, w2, w3, new_word};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d      = S_READY;
                    key_loaded_d = 1'b1;
                end
            end
            S_READY: begin
                if (key_valid) begin
                    win_d        = key ^ FK;
                    cnt_d        = 5'd0;
                    key_loaded_d = 1'b0;
                    state_d      = S_KEYEXP;
                end else if (in_valid) begin
                    win_d   = in_data;
                    cnt_d   = 5'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                win_d = {w1, w2, w3, new_word};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    // Final reverse transform R: {X35, X34, X33, X32}
                    out_data_d  = {new_word, w3, w2, w1};
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_READY;
                end
            end
            default: begin
                // Unreachable encodings: return to a clean, keyless IDLE
                state_d      = S_IDLE;
                key_loaded_d = 1'b0;
                out_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 5'd0;
            win_q        <= '0;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            key_loaded_q <= key_loaded_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // The store is never cleared; key_loaded qualifies its contents.
    always_ff @(posedge clk) begin
        if (rk_we && !reset) begin
            rk_q[cnt_q] <= new_word;
        end
    end

    assign key_ready  = (state_q == S_IDLE) || (state_q == S_READY);
    assign in_ready   = (state_q == S_READY) && !key_valid;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign key_loaded = key_loaded_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/sm4_decrypt_stream.md
Name: sm4_decrypt_stream

Overview:
- Streaming SM4 (GB/T 32907) block decryptor.
- Loads a 128-bit key once and expands and stores all 32 round keys. It then decrypts any number of 128-bit ciphertext blocks under that key, one round per cycle, applying the round keys in reverse order.
- Sits between a ciphertext source and a plaintext sink, with valid/ready handshakes on the key, input and output channels.

Parameters:
- WIDTH, 128, block and key width. Only 128 is legal; any other value is an elaboration error.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- key_valid  input  1  key offered
- key_ready  output  1  key accepted when key_valid && key_ready
- key  input  128  master key MK, with MK0 = key[127:96]
- in_valid  input  1  ciphertext block offered
- in_ready  output  1  block accepted when in_valid && in_ready
- in_data  input  128  ciphertext, with X0 = in_data[127:96]
- out_valid  output  1  plaintext valid
- out_ready  input  1  sink accepts when out_valid && out_ready
- out_data  output  128  plaintext
- key_loaded  output  1  a valid round-key set is stored

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; round counter=0; key_loaded=0; out_valid=0; out_data=0.
  - The round-key store does not need clearing, but it is treated as invalid.
  - Reset aborts any key expansion or decryption in progress. Partial results are discarded and a new key must be loaded.
- States: IDLE, KEYEXP, READY, ROUND, OUT.
- key_ready = (state==IDLE || state==READY). It is low in KEYEXP, ROUND and OUT.
- in_ready = (state==READY) && !key_valid. A key offer takes priority over a data offer in the same cycle.
- IDLE:
  - On key handshake: latch K0..K3 = MKi ^ FKi, with FK = a3b1bac6, 56aa3350, 677d9197, b27022dc. Counter=0. Go to KEYEXP.
- KEYEXP:
  - Each cycle computes rk[i] = K(i+4) = Ki ^ T'(K(i+1) ^ K(i+2) ^ K(i+3) ^ CKi), writes it to store slot i, and shifts the K window.
  - CKi bytes are (4i+j)*7 mod 256 for j = 0..3, most significant byte first. These are generated arithmetically or by a 32-entry ROM.
  - After i=31 is written: go to READY, key_loaded=1.
  - Latency: key handshake on edge K; rk[0..31] written on edges K+1..K+32; key_ready high again from edge K+32.
- READY:
  - Key handshake re-keys: go to KEYEXP and set key_loaded=0 until the new expansion completes.
  - Else input handshake: latch X0..X3, counter=0, go to ROUND.
- ROUND:
  - Each cycle: X(n+4) = Xn ^ T(X(n+1) ^ X(n+2) ^ X(n+3) ^ rk[31-n]), then shift the window.
- T and T' transforms (both 32-bit, rotations are rotate-left):
  - T = L(tau(.)), with L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
  - T' = L'(tau(.)), with L'(B) = B ^ B<<<13 ^ B<<<23.
  - tau applies the standard SM4 8-bit S-box to each of the 4 bytes.
  - One S-box/T datapath is shared between KEYEXP and ROUND. The two states are mutually exclusive.
- ROUND exit:
  - After n=31: out_data = {X35, X34, X33, X32}, out_valid=1, go to OUT.
  - Latency: input handshake on edge E; rounds on edges E+1..E+32; out_valid high from edge E+32.
- OUT:
  - out_data and out_valid are held stable until out_ready=1.
  - On output handshake: out_valid=0, go to READY. The next input can be accepted on the following cycle at the earliest.
  - Throughput is therefore at most one block per 34 cycles.
- Illegal state encodings recover to IDLE.
- in_valid while in IDLE or KEYEXP is ignored, because in_ready is low. The source must hold the block.

Test Plan:
- Known answer: load key 0123456789abcdeffedcba9876543210, then send in_data 681edf34d206965e86b3e94f536e4246 -> out_data 0123456789abcdeffedcba9876543210. out_valid must rise exactly 32 cycles after the in handshake, and key_ready must rise 32 cycles after the key handshake.
- Multi-block with one key: send 3 back-to-back copies of the vector above with out_ready held at 1 -> 3 identical correct outputs. Each output handshake must come at least 34 cycles after the previous one, and there must be no re-expansion (key_loaded stays 1).
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0 and key_ready=0 throughout. Releasing out_ready gives one handshake and then READY.
- Key priority and re-key: assert key_valid and in_valid together in READY -> key accepted, in_ready=0, key_loaded=0 for 32 cycles. The block decrypted afterwards uses the new key (check with a second key/ciphertext pair computed by the reference model).
- Reset mid-operation: assert reset at round 15 of a decrypt, and separately at cycle 10 of KEYEXP -> next cycle state=IDLE, out_valid=0, key_loaded=0, in_ready=0. A fresh key plus block then gives the correct result.
- Random: 200 random key/block pairs with random valid and out_ready stalls, compared against the C reference model decryption -> zero mismatches and no dropped or duplicated handshakes.
